eq_band_mixer: RTL

//  Parametrised successor to the fixed 5-band stereo engine. Per frame: sums NUM_BANDS filtered band samples
//  per channel, each weighted by a signed gain, then applies master volume and saturates to 16 bits.

---
 rtl/eq_pkg.sv | 27 ++
 rtl/eq_mac_lane.sv | 81 ++++++++
 rtl/eq_band_mixer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// Shared types and helpers for the eq_band_mixer slice: FSM state encoding,
// sample width and the 16-bit saturation function used by both mixer lanes.
package eq_pkg;

  localparam int SAMPLE_W = 16;
  localparam int SAT_IN_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } eq_state_e;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAT_IN_W-1:0] x);
    logic signed [SAMPLE_W-1:0] r;
    if (x > 64'sd32767) begin
      r = 16'sh7FFF;
    end else if (x < -64'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = x[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/eq_mac_lane.sv
// One mixer lane: band*gain accumulator, gain-scale shift, volume multiply and saturation.
// EQ_ROUNDING_EN selects round-half-up on both shifts; otherwise they truncate toward -inf.
module eq_mac_lane
  import eq_pkg::*;
#(
  parameter int NUM_BANDS = 5,
  parameter int GAIN_W    = 13,
  parameter int VOL_W     = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       mac_en,
  input  logic signed [SAMPLE_W-1:0] band,
  input  logic signed [GAIN_W-1:0]   gain,
  input  logic        [VOL_W-1:0]    volume,
  output logic signed [SAMPLE_W-1:0] mix_out
);

  localparam int PROD_W = SAMPLE_W + GAIN_W;
  localparam int ACC_W  = PROD_W + $clog2(NUM_BANDS);
  localparam int MIX_SH = GAIN_W - 2;
  localparam int VMUL_W = SAMPLE_W + VOL_W + 1;

`ifdef EQ_ROUNDING_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  localparam logic [ACC_W-1:0]  MIX_BIAS = ACC_W'(1'b1) << (MIX_SH - 1);
  localparam logic [VMUL_W-1:0] VOL_BIAS = VMUL_W'(1'b1) << (VOL_W - 1);

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic        [PROD_W-1:0]   prod_s;
  logic signed [ACC_W-1:0]    mix_rnd_s, mix_sh_s;
  logic signed [SAMPLE_W-1:0] mix16_s;
  logic        [VMUL_W-1:0]   vprod_s;
  logic signed [VMUL_W-1:0]   vol_rnd_s, vol_sh_s;

  // Multiply-accumulate and the combinational scale/volume/saturate path read in SCALE.
  always_comb begin
    // Operands are sign/zero-extended to the result width, so the low bits are the exact product.
    prod_s = {{GAIN_W{band[SAMPLE_W-1]}}, band} * {{SAMPLE_W{gain[GAIN_W-1]}}, gain};

    if (clr) begin
      acc_d = '0;
    end else if (mac_en) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
    end else begin
      acc_d = acc_q;
    end

    if (ROUND_EN) begin
      mix_rnd_s = acc_q + MIX_BIAS;
    end else begin
      mix_rnd_s = acc_q;
    end
    mix_sh_s = mix_rnd_s >>> MIX_SH;
    mix16_s  = sat16({{(SAT_IN_W-ACC_W){mix_sh_s[ACC_W-1]}}, mix_sh_s});

    vprod_s = {{(VOL_W+1){mix16_s[SAMPLE_W-1]}}, mix16_s} * {{SAMPLE_W{1'b0}}, 1'b0, volume};
    if (ROUND_EN) begin
      vol_rnd_s = vprod_s + VOL_BIAS;
    end else begin
      vol_rnd_s = vprod_s;
    end
    vol_sh_s = vol_rnd_s >>> VOL_W;
    mix_out  = sat16({{(SAT_IN_W-VMUL_W){vol_sh_s[VMUL_W-1]}}, vol_sh_s});
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/eq_band_mixer.sv
// Stereo N-band weighted mixer with master volume and warm-up mute / amp-enable sequencing.
// Optional build macro EQ_ROUNDING_EN (consumed in eq_mac_lane) enables round-half-up shifts.
module eq_band_mixer
  import eq_pkg::*;
#(
  parameter int NUM_BANDS     = 5,
  parameter int GAIN_W        = 13,
  parameter int VOL_W         = 12,
  parameter int WARMUP_FRAMES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [SAMPLE_W*NUM_BANDS-1:0]   lft_band,
  input  logic [SAMPLE_W*NUM_BANDS-1:0]   rht_band,
  input  logic [GAIN_W*NUM_BANDS-1:0]     gain,
  input  logic [VOL_W-1:0]                volume,
  output logic signed [SAMPLE_W-1:0]      lft_out,
  output logic signed [SAMPLE_W-1:0]      rht_out,
  output logic                            out_valid,
  output logic                            amp_on,
  output logic                            busy,
  output logic                            overrun
);

  localparam int IDX_W = $clog2(NUM_BANDS);
  localparam int CNT_W = $clog2(WARMUP_FRAMES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);
  localparam logic [CNT_W-1:0] WARM_MAX = CNT_W'(WARMUP_FRAMES);

  eq_state_e                       state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [SAMPLE_W*NUM_BANDS-1:0]   lft_band_q, lft_band_d;
  logic [SAMPLE_W*NUM_BANDS-1:0]   rht_band_q, rht_band_d;
  logic [GAIN_W*NUM_BANDS-1:0]     gain_q, gain_d;
  logic [VOL_W-1:0]                volume_q, volume_d;
  logic signed [SAMPLE_W-1:0]      lft_out_q, lft_out_d;
  logic signed [SAMPLE_W-1:0]      rht_out_q, rht_out_d;
  logic                            out_valid_q, out_valid_d;
  logic                            busy_q, busy_d;
  logic                            overrun_q, overrun_d;
  logic                            amp_on_q, amp_on_d;
  logic [CNT_W-1:0]                warm_cnt_q, warm_cnt_d;

  logic                            lane_clr_s, lane_mac_s, mute_s;
  logic signed [SAMPLE_W-1:0]      lft_sel_s, rht_sel_s;
  logic signed [GAIN_W-1:0]        gain_sel_s;
  logic signed [SAMPLE_W-1:0]      lft_mix_s, rht_mix_s;

  // Next-state, capture, output and warm-up logic for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lft_band_d  = lft_band_q;
    rht_band_d  = rht_band_q;
    gain_d      = gain_q;
    volume_d    = volume_q;
    lft_out_d   = lft_out_q;
    rht_out_d   = rht_out_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    lane_clr_s  = 1'b0;
    lane_mac_s  = (state_q == MAC);
    mute_s      = (warm_cnt_q < WARM_MAX);

    lft_sel_s  = lft_band_q[SAMPLE_W*int'(idx_q) +: SAMPLE_W];
    rht_sel_s  = rht_band_q[SAMPLE_W*int'(idx_q) +: SAMPLE_W];
    gain_sel_s = gain_q[GAIN_W*int'(idx_q) +: GAIN_W];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          lft_band_d = lft_band;
          rht_band_d = rht_band;
          gain_d     = gain;
          volume_d   = volume;
          idx_d      = '0;
          busy_d     = 1'b1;
          lane_clr_s = 1'b1;
          state_d    = MAC;
        end else begin
          busy_d = 1'b0;
        end
      end
      MAC: begin
        if (idx_q == LAST_IDX) begin
          state_d = SCALE;
        end else begin
          idx_d = idx_q + IDX_W'(1'b1);
        end
      end
      SCALE: begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        lft_out_d   = mute_s ? 16'sd0 : lft_mix_s;
        rht_out_d   = mute_s ? 16'sd0 : rht_mix_s;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A request arriving while busy (DONE included) is dropped, not queued.
    if (in_valid && busy_q) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    if (out_valid_q && (warm_cnt_q != WARM_MAX)) begin
      warm_cnt_d = warm_cnt_q + CNT_W'(1'b1);
    end else begin
      warm_cnt_d = warm_cnt_q;
    end
    amp_on_d = amp_on_q | (warm_cnt_d == WARM_MAX);
  end

  // Sequencer, holding and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lft_band_q  <= '0;
      rht_band_q  <= '0;
      gain_q      <= '0;
      volume_q    <= '0;
      lft_out_q   <= '0;
      rht_out_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      amp_on_q    <= 1'b0;
      warm_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lft_band_q  <= lft_band_d;
      rht_band_q  <= rht_band_d;
      gain_q      <= gain_d;
      volume_q    <= volume_d;
      lft_out_q   <= lft_out_d;
      rht_out_q   <= rht_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      amp_on_q    <= amp_on_d;
      warm_cnt_q  <= warm_cnt_d;
    end
  end

  eq_mac_lane #(.NUM_BANDS(NUM_BANDS), .GAIN_W(GAIN_W), .VOL_W(VOL_W)) u_lane_lft (
    .clk     (clk),
    .rst     (rst),
    .clr     (lane_clr_s),
    .mac_en  (lane_mac_s),
    .band    (lft_sel_s),
    .gain    (gain_sel_s),
    .volume  (volume_q),
    .mix_out (lft_mix_s)
  );

  eq_mac_lane #(.NUM_BANDS(NUM_BANDS), .GAIN_W(GAIN_W), .VOL_W(VOL_W)) u_lane_rht (
    .clk     (clk),
    .rst     (rst),
    .clr     (lane_clr_s),
    .mac_en  (lane_mac_s),
    .band    (rht_sel_s),
    .gain    (gain_sel_s),
    .volume  (volume_q),
    .mix_out (rht_mix_s)
  );

  assign lft_out   = lft_out_q;
  assign rht_out   = rht_out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign amp_on    = amp_on_q;

endmodule
